// File: rtl/dot_accumulator_if.sv
// dot_accumulator_if
// Bundles the control, term-stream and result-stream signals of the
// dot_accumulator block.
//   start/len           : control unit -> accumulator, begin a vector
//   in_valid/in_data    : term source -> accumulator
//   in_ready            : accumulator -> term source
//   out_valid/out_sum/out_count/overflow : accumulator -> result sink
//   out_ready           : result sink -> accumulator
//   busy                : accumulator status (state is not IDLE)
// The master modport is the environment side; the slave modport is the block.
interface dot_accumulator_if #(
  parameter int WIDTH     = 32,
  parameter int ACC_WIDTH = 48,
  parameter int LEN_WIDTH = 8
);
  logic                 start;
  logic [LEN_WIDTH-1:0] len;
  logic                 in_valid;
  logic [WIDTH-1:0]     in_data;
  logic                 in_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_sum;
  logic [LEN_WIDTH-1:0] out_count;
  logic                 overflow;
  logic                 busy;

  modport master (
    output start, len, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_count, overflow, busy
  );

  modport slave (
    input  start, len, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_count, overflow, busy
  );
endinterface

// File: rtl/dot_accumulator.sv
// dot_accumulator
// Sums a programmed number of unsigned terms from the pipeline stage into a
// wide accumulator and presents the total over a valid/ready handshake.
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset, discards any partial result
//   bus   : dot_accumulator_if slave (start/len, term stream, result stream,
//           busy status)
// The parameters must match those of the connected interface instance.
module dot_accumulator #(
  parameter int WIDTH     = 32,
  parameter int ACC_WIDTH = 48,
  parameter int LEN_WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  dot_accumulator_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  logic [ACC_WIDTH-1:0] acc;
  logic [LEN_WIDTH-1:0] count;
  logic [LEN_WIDTH-1:0] len_reg;
  logic                 ovf;

  // One extra bit above the accumulator captures the carry out of the add.
  logic [ACC_WIDTH:0]   sum_next;
  logic [LEN_WIDTH-1:0] count_next;

  always_comb begin
    sum_next   = {1'b0, acc} + (ACC_WIDTH+1)'(bus.in_data);
    count_next = count + 1'b1;
  end

  // Control FSM and datapath registers. A zero-length vector skips ACC and
  // reports an empty result directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      count   <= '0;
      len_reg <= '0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc     <= '0;
            count   <= '0;
            ovf     <= 1'b0;
            len_reg <= bus.len;
            state   <= (bus.len != '0) ? ACC : DONE;
          end
        end
        ACC: begin
          if (bus.in_valid) begin
            acc   <= sum_next[ACC_WIDTH-1:0];
            count <= count_next;
            if (sum_next[ACC_WIDTH]) ovf <= 1'b1;
            if (count_next == len_reg) state <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake outputs decode the state register only, so no input reaches
  // them combinationally.
  assign bus.in_ready  = (state == ACC);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_sum   = acc;
  assign bus.out_count = count;
  assign bus.overflow  = ovf;

endmodule

// File: tb/tb_dot_accumulator.sv
// tb_dot_accumulator
// Self-checking bench for dot_accumulator. A small model accumulates the
// expected result while terms are driven; finished expectations go into a
// scoreboard queue and are popped when the block raises out_valid.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_dot_accumulator;

  localparam int WIDTH     = 32;
  localparam int ACC_WIDTH = 32;
  localparam int LEN_WIDTH = 8;

  typedef struct {
    logic [ACC_WIDTH-1:0] sum;
    logic [LEN_WIDTH-1:0] cnt;
    logic                 ovf;
  } exp_t;

  logic clk;
  logic rst_n;

  dot_accumulator_if #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH), .LEN_WIDTH(LEN_WIDTH)) bus ();

  dot_accumulator #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH), .LEN_WIDTH(LEN_WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  exp_t sb[$];

  logic [ACC_WIDTH-1:0] m_sum;
  logic [LEN_WIDTH-1:0] m_cnt;
  logic                 m_ovf;

  // Reference model: plain modular addition with carry detection.
  task automatic model_clear();
    m_sum = '0;
    m_cnt = '0;
    m_ovf = 1'b0;
  endtask

  task automatic model_add(input logic [WIDTH-1:0] d);
    logic [ACC_WIDTH:0] t;
    t = {1'b0, m_sum} + {{(ACC_WIDTH+1-WIDTH){1'b0}}, d};
    m_sum = t[ACC_WIDTH-1:0];
    if (t[ACC_WIDTH]) m_ovf = 1'b1;
    m_cnt = m_cnt + 1'b1;
  endtask

  task automatic model_push();
    exp_t e;
    e.sum = m_sum;
    e.cnt = m_cnt;
    e.ovf = m_ovf;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic issue_start(input logic [LEN_WIDTH-1:0] n);
    bus.start = 1'b1;
    bus.len   = n;
    tick();
    bus.start = 1'b0;
    bus.len   = 8'd77;
    model_clear();
  endtask

  task automatic feed(input logic [WIDTH-1:0] d, input int gaps);
    bus.in_valid = 1'b0;
    repeat (gaps) tick();
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    tick();
    bus.in_valid = 1'b0;
    model_add(d);
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (bus.out_valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    if (bus.out_valid !== 1'b1) begin
      checks++;
      $display("[TB] FAIL wait_out_valid: out_valid=%b after %0d cycles, required 1", bus.out_valid, budget);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.busy, bus.overflow} !== 4'b0000 ||
        bus.out_sum !== '0 || bus.out_count !== '0)
      $display("[TB] FAIL reset_state: rdy=%b vld=%b busy=%b ovf=%b sum=%h cnt=%0d, required all 0",
               bus.in_ready, bus.out_valid, bus.busy, bus.overflow, bus.out_sum, bus.out_count);
    else passes++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    exp_t e;
    issue_start(8'd2);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b1)
      $display("[TB] FAIL basic_start: in_ready=%b busy=%b, required 1 1", bus.in_ready, bus.busy);
    else passes++;
    feed(32'd11, 0);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_count !== 8'd1)
      $display("[TB] FAIL basic_mid: out_valid=%b count=%0d, required 0 1", bus.out_valid, bus.out_count);
    else passes++;
    feed(32'd1, 0);
    model_push();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
      $display("[TB] FAIL basic_latency: out_valid=%b in_ready=%b, required 1 0", bus.out_valid, bus.in_ready);
    else passes++;
    wait_valid(4);
    e = sb.pop_front();
    checks++;
    if (bus.out_sum !== e.sum || bus.out_count !== e.cnt || bus.overflow !== e.ovf)
      $display("[TB] FAIL basic_result: sum=%0d cnt=%0d ovf=%b, required %0d %0d %b",
               bus.out_sum, bus.out_count, bus.overflow, e.sum, e.cnt, e.ovf);
    else passes++;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0)
      $display("[TB] FAIL basic_drain: busy=%b out_valid=%b, required 0 0", bus.busy, bus.out_valid);
    else passes++;
  endtask

  task automatic test_stall_backpressure();
    exp_t e;
    issue_start(8'd3);
    feed(32'd5, 2);
    bus.in_data = 32'hDEAD;
    tick();
    checks++;
    if (bus.out_count !== 8'd1 || bus.out_sum !== 32'd5)
      $display("[TB] FAIL stall_hold: count=%0d sum=%0d, required 1 5", bus.out_count, bus.out_sum);
    else passes++;
    feed(32'd7, 1);
    feed(32'd9, 2);
    model_push();
    wait_valid(4);
    e = sb.pop_front();
    repeat (4) begin
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_sum !== e.sum || bus.out_count !== e.cnt)
        $display("[TB] FAIL backpressure_hold: vld=%b sum=%0d cnt=%0d, required 1 %0d %0d",
                 bus.out_valid, bus.out_sum, bus.out_count, e.sum, e.cnt);
      else passes++;
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++;
    if (bus.busy !== 1'b0)
      $display("[TB] FAIL backpressure_release: busy=%b, required 0", bus.busy);
    else passes++;
  endtask

  task automatic test_overflow();
    exp_t e;
    issue_start(8'd2);
    feed(32'hFFFF_FFFF, 0);
    feed(32'h0000_0002, 0);
    model_push();
    wait_valid(4);
    e = sb.pop_front();
    checks++;
    if (bus.out_sum !== e.sum || bus.overflow !== e.ovf || bus.out_count !== e.cnt)
      $display("[TB] FAIL overflow_wrap: sum=%h ovf=%b cnt=%0d, required %h %b %0d",
               bus.out_sum, bus.overflow, bus.out_count, e.sum, e.ovf, e.cnt);
    else passes++;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    issue_start(8'd1);
    checks++;
    if (bus.overflow !== 1'b0 || bus.out_sum !== '0)
      $display("[TB] FAIL overflow_clear: ovf=%b sum=%h, required 0 0", bus.overflow, bus.out_sum);
    else passes++;
    feed(32'd3, 0);
    model_push();
    wait_valid(4);
    e = sb.pop_front();
    checks++;
    if (bus.out_sum !== e.sum || bus.overflow !== e.ovf)
      $display("[TB] FAIL overflow_after: sum=%0d ovf=%b, required %0d %b",
               bus.out_sum, bus.overflow, e.sum, e.ovf);
    else passes++;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_zero_len();
    exp_t e;
    issue_start(8'd0);
    model_push();
    e = sb.pop_front();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_sum !== e.sum || bus.out_count !== e.cnt)
      $display("[TB] FAIL zero_len: vld=%b rdy=%b sum=%0d cnt=%0d, required 1 0 %0d %0d",
               bus.out_valid, bus.in_ready, bus.out_sum, bus.out_count, e.sum, e.cnt);
    else passes++;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'd55;
    tick();
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_sum !== '0 || bus.out_count !== '0 || bus.out_valid !== 1'b1)
      $display("[TB] FAIL zero_len_no_beat: sum=%0d cnt=%0d vld=%b, required 0 0 1",
               bus.out_sum, bus.out_count, bus.out_valid);
    else passes++;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_ignored();
    exp_t e;
    issue_start(8'd3);
    feed(32'd2, 0);
    bus.start = 1'b1;
    bus.len   = 8'd5;
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.out_count !== 8'd1 || bus.in_ready !== 1'b1 || bus.out_sum !== 32'd2)
      $display("[TB] FAIL ignore_start_acc: cnt=%0d rdy=%b sum=%0d, required 1 1 2",
               bus.out_count, bus.in_ready, bus.out_sum);
    else passes++;
    feed(32'd3, 0);
    feed(32'd4, 0);
    model_push();
    wait_valid(4);
    e = sb.pop_front();
    bus.start    = 1'b1;
    bus.len      = 8'd1;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'd100;
    tick();
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== e.sum || bus.out_count !== e.cnt)
      $display("[TB] FAIL ignore_in_done: vld=%b sum=%0d cnt=%0d, required 1 %0d %0d",
               bus.out_valid, bus.out_sum, bus.out_count, e.sum, e.cnt);
    else passes++;
    bus.out_ready = 1'b1;
    bus.start     = 1'b1;
    bus.len       = 8'd2;
    tick();
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    checks++;
    if (bus.busy !== 1'b0)
      $display("[TB] FAIL ignore_start_drain: busy=%b, required 0", bus.busy);
    else passes++;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    issue_start(8'd3);
    feed(32'd8, 0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.busy, bus.overflow} !== 4'b0000 ||
        bus.out_sum !== '0 || bus.out_count !== '0)
      $display("[TB] FAIL reset_mid: rdy=%b vld=%b busy=%b ovf=%b sum=%0d cnt=%0d, required all 0",
               bus.in_ready, bus.out_valid, bus.busy, bus.overflow, bus.out_sum, bus.out_count);
    else passes++;
    tick();
    rst_n = 1'b1;
    tick();
    issue_start(8'd1);
    feed(32'd4, 0);
    model_push();
    wait_valid(4);
    e = sb.pop_front();
    checks++;
    if (bus.out_sum !== e.sum || bus.out_count !== e.cnt || bus.overflow !== e.ovf)
      $display("[TB] FAIL reset_fresh_run: sum=%0d cnt=%0d ovf=%b, required %0d %0d %b",
               bus.out_sum, bus.out_count, bus.overflow, e.sum, e.cnt, e.ovf);
    else passes++;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    model_clear();
    test_reset();
    test_basic();
    test_stall_backpressure();
    test_overflow();
    test_zero_len();
    test_ignored();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
